// File: rtl/mod12_mon_pkg.sv
// ---------------------------------------------------------------------------
// mod12_mon_pkg
// Shared definitions for the mod-12 counter protocol monitor.
//   CNT_W        width of the observed counter value
//   MOD_MAX      largest legal counter value (11)
//   mon_state_e  monitor FSM encoding, also driven out on state_o
//   next_count() reference model of one counter step
// ---------------------------------------------------------------------------
package mod12_mon_pkg;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] MOD_MAX = 4'd11;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAIL  = 2'd2
    } mon_state_e;

    // One step of the counter: load wins over mode, both directions wrap
    // inside 0..MOD_MAX.
    function automatic logic [CNT_W-1:0] next_count(
        input logic             load,
        input logic             mode,
        input logic [CNT_W-1:0] datain,
        input logic [CNT_W-1:0] cur
    );
        logic [CNT_W-1:0] res;
        res = '0;
        if (load) begin
            res = datain;
        end else if (mode) begin
            res = (cur == MOD_MAX) ? '0 : cur + 4'd1;
        end else begin
            res = (cur == '0) ? MOD_MAX : cur - 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mod12_sat_counter.sv
// ---------------------------------------------------------------------------
// mod12_sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset, clears the count
//   inc_i    count one event this cycle
//   count_o  current count (ERR_W bits)
// ---------------------------------------------------------------------------
module mod12_sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [ERR_W-1:0] count_o
);

    logic [ERR_W-1:0] count_q;
    logic [ERR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mod12_counter_monitor.sv
// ---------------------------------------------------------------------------
// mod12_counter_monitor
// Passive scoreboard for the mod-12 up/down counter. Every edge it samples
// the counter's controls and its current output, predicts the value the
// counter must show one edge later, and on that later edge compares.
// The prediction is always rebuilt from the observed dataout, so one bad
// step from the counter costs exactly one err_pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   datain       counter load value seen on the interface
//   load         counter load strobe
//   mode         counter direction (1 = up, 0 = down)
//   dataout      counter output under observation
//   expected     predicted dataout for the current cycle
//   err_pulse    one-cycle flag: mismatch or out-of-range value
//   err_count    saturating count of err_pulse events
//   match_count  saturating count of checked-and-matched cycles
//   state_o      current FSM state (mon_state_e)
// Optional (macro MOD12_MON_WRAP_COV_EN):
//   up_wrap_cnt    matched 11->0 up transitions seen in TRACK
//   down_wrap_cnt  matched 0->11 down transitions seen in TRACK
//
// There is no handshake on this block: every input is sampled on every
// rising clk edge and every output is a register valid for the full cycle.
// ---------------------------------------------------------------------------
module mod12_counter_monitor
    import mod12_mon_pkg::*;
#(
    parameter int ERR_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       datain,
    input  logic             load,
    input  logic             mode,
    input  logic [3:0]       dataout,
    output logic [3:0]       expected,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] match_count,
`ifdef MOD12_MON_WRAP_COV_EN
    output logic [ERR_W-1:0] up_wrap_cnt,
    output logic [ERR_W-1:0] down_wrap_cnt,
`endif
    output logic [1:0]       state_o
);

    mon_state_e       state_q;
    logic [3:0]       expected_q;
    logic [3:0]       expected_d;
    logic             err_pulse_q;

    logic             dout_legal;
    logic             illegal_load;
    logic             mismatch;
    logic             matched;

    always_comb begin
        dout_legal   = (dataout <= MOD_MAX);
        // A load above MOD_MAX leaves the counter's next value undefined,
        // so the cycle after it must not be compared.
        illegal_load = load && (datain > MOD_MAX);
        // An out-of-range value is an error whatever was predicted.
        mismatch     = (state_q == TRACK) && (!dout_legal || (dataout != expected_q));
        matched      = (state_q == TRACK) && !mismatch;
        expected_d   = next_count(load, mode, datain, dataout);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SYNC;
            expected_q  <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= mismatch;
            // FAIL freezes the prediction along with everything else.
            if (state_q != FAIL) begin
                expected_q <= expected_d;
            end
            case (state_q)
                SYNC: begin
                    if (dout_legal && !illegal_load) begin
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    if (mismatch && STOP_ON_ERR) begin
                        state_q <= FAIL;
                    end else if (!dout_legal || illegal_load) begin
                        // Cannot step the model from an illegal value.
                        state_q <= SYNC;
                    end
                end
                FAIL: begin
                    state_q <= FAIL;
                end
                default: begin
                    state_q <= SYNC;
                end
            endcase
        end
    end

    mod12_sat_counter #(.ERR_W(ERR_W)) u_err_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (mismatch),
        .count_o (err_count)
    );

    mod12_sat_counter #(.ERR_W(ERR_W)) u_match_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (matched),
        .count_o (match_count)
    );

`ifdef MOD12_MON_WRAP_COV_EN
    // Armed when the sampled step is a plain count sitting on the wrap
    // point; the wrap is credited only if the next compare matches.
    logic up_arm_q;
    logic dn_arm_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_arm_q <= 1'b0;
            dn_arm_q <= 1'b0;
        end else begin
            up_arm_q <= !load && mode && (dataout == MOD_MAX);
            dn_arm_q <= !load && !mode && (dataout == '0);
        end
    end

    mod12_sat_counter #(.ERR_W(ERR_W)) u_up_wrap_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (matched && up_arm_q),
        .count_o (up_wrap_cnt)
    );

    mod12_sat_counter #(.ERR_W(ERR_W)) u_down_wrap_cnt (
        .clk     (clk),
        .rst_n   (rst),
        .inc_i   (matched && dn_arm_q),
        .count_o (down_wrap_cnt)
    );
`endif

    assign expected  = expected_q;
    assign err_pulse = err_pulse_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mod12_counter_monitor.sv
// ---------------------------------------------------------------------------
// tb_mod12_counter_monitor
// Two monitors watch the same stimulus: u_trk keeps tracking after errors,
// u_stp (STOP_ON_ERR=1, narrow counters) goes sticky on its first error.
// The bench plays the counter itself and can corrupt its output.
// Build with +define+MOD12_MON_WRAP_COV_EN to also check the wrap counters.
// ---------------------------------------------------------------------------
module tb_mod12_counter_monitor;
    import mod12_mon_pkg::*;

    localparam int W0 = 8;
    localparam int W1 = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] datain  = '0;
    logic [3:0] dataout = '0;
    logic       load    = 1'b0;
    logic       mode    = 1'b0;

    logic [3:0]    exp0, exp1;
    logic          pl0, pl1;
    logic [W0-1:0] ec0, mc0;
    logic [W1-1:0] ec1, mc1;
    logic [1:0]    st0, st1;
`ifdef MOD12_MON_WRAP_COV_EN
    logic [W0-1:0] uw0, dw0;
    logic [W1-1:0] uw1, dw1;
`endif

    mod12_counter_monitor #(.ERR_W(W0), .STOP_ON_ERR(1'b0)) u_trk (
        .clk(clk), .rst(rst), .datain(datain), .load(load), .mode(mode),
        .dataout(dataout), .expected(exp0), .err_pulse(pl0),
        .err_count(ec0), .match_count(mc0),
`ifdef MOD12_MON_WRAP_COV_EN
        .up_wrap_cnt(uw0), .down_wrap_cnt(dw0),
`endif
        .state_o(st0)
    );

    mod12_counter_monitor #(.ERR_W(W1), .STOP_ON_ERR(1'b1)) u_stp (
        .clk(clk), .rst(rst), .datain(datain), .load(load), .mode(mode),
        .dataout(dataout), .expected(exp1), .err_pulse(pl1),
        .err_count(ec1), .match_count(mc1),
`ifdef MOD12_MON_WRAP_COV_EN
        .up_wrap_cnt(uw1), .down_wrap_cnt(dw1),
`endif
        .state_o(st1)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(input string name, input int act, input int want);
        n_tests++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Holds the last sample taken and the bookkeeping the outputs must show.
    mon_state_e m_state [2];
    int         m_exp   [2];
    bit         m_exp_ok[2];
    int         m_pulse [2];
    int         m_err   [2];
    int         m_match [2];
    int         m_upw   [2];
    int         m_dnw   [2];
    bit         s_ld    [2];
    bit         s_md    [2];
    int         s_din   [2];
    int         s_dout  [2];
    int         cmax    [2];

    function automatic int ref_next(input bit ld, input bit md, input int din, input int cur);
        if (ld) return din;
        return md ? (cur + 1) % 12 : (cur + 11) % 12;
    endfunction

    function automatic int sat_inc(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = SYNC;  m_exp[i] = 0;   m_exp_ok[i] = 1'b1;
            m_pulse[i] = 0;     m_err[i] = 0;   m_match[i] = 0;
            m_upw[i] = 0;       m_dnw[i] = 0;
            s_ld[i] = 1'b0;     s_md[i] = 1'b0; s_din[i] = 0; s_dout[i] = 0;
        end
    endtask

    task automatic model_edge(input int i);
        int         d;
        int         pred;
        bit         illegal;
        bit         stop;
        mon_state_e nxt;
        d       = int'(dataout);
        illegal = load && (int'(datain) > 11);
        stop    = (i == 1);
        pred    = ref_next(s_ld[i], s_md[i], s_din[i], s_dout[i]);
        nxt     = m_state[i];
        m_pulse[i] = 0;
        if (m_state[i] == SYNC) begin
            nxt = (d <= 11 && !illegal) ? TRACK : SYNC;
        end else if (m_state[i] == TRACK) begin
            if (d > 11 || d != pred) begin
                m_pulse[i] = 1;
                m_err[i]   = sat_inc(m_err[i], cmax[i]);
                nxt = stop ? FAIL : ((d > 11) ? SYNC : TRACK);
            end else begin
                m_match[i] = sat_inc(m_match[i], cmax[i]);
                if (!s_ld[i] && s_md[i] && s_dout[i] == 11) m_upw[i] = sat_inc(m_upw[i], cmax[i]);
                if (!s_ld[i] && !s_md[i] && s_dout[i] == 0) m_dnw[i] = sat_inc(m_dnw[i], cmax[i]);
            end
            if (nxt == TRACK && illegal) nxt = SYNC;
        end
        if (m_state[i] != FAIL) begin
            s_ld[i] = load; s_md[i] = mode; s_din[i] = int'(datain); s_dout[i] = d;
            m_exp[i]    = ref_next(load, mode, int'(datain), d);
            m_exp_ok[i] = (d <= 11) && !illegal;
        end
        m_state[i] = nxt;
    endtask

    initial begin
        cmax[0] = (1 << W0) - 1;
        cmax[1] = (1 << W1) - 1;
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else for (int i = 0; i < 2; i++) model_edge(i);
        end
    end

    // ---------------- compare process ----------------
    task automatic cmp(input int i, input int st, input int ex, input int pl,
                       input int ec, input int mc, input int uw, input int dw);
        string p;
        p = (i == 0) ? "trk." : "stp.";
        check({p, "state"}, st, int'(m_state[i]));
        if (m_exp_ok[i]) check({p, "expected"}, ex, m_exp[i]);
        check({p, "err_pulse"}, pl, m_pulse[i]);
        check({p, "err_count"}, ec, m_err[i]);
        check({p, "match_count"}, mc, m_match[i]);
`ifdef MOD12_MON_WRAP_COV_EN
        check({p, "up_wrap"}, uw, m_upw[i]);
        check({p, "down_wrap"}, dw, m_dnw[i]);
`endif
    endtask

    initial begin
        forever begin
            @(negedge clk);
`ifdef MOD12_MON_WRAP_COV_EN
            cmp(0, int'(st0), int'(exp0), int'(pl0), int'(ec0), int'(mc0), int'(uw0), int'(dw0));
            cmp(1, int'(st1), int'(exp1), int'(pl1), int'(ec1), int'(mc1), int'(uw1), int'(dw1));
`else
            cmp(0, int'(st0), int'(exp0), int'(pl0), int'(ec0), int'(mc0), 0, 0);
            cmp(1, int'(st1), int'(exp1), int'(pl1), int'(ec1), int'(mc1), 0, 0);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    int ctr = 0;   // the bench's own counter value

    // Present the counter's current value plus controls, advance the
    // counter, return just after the sampling edge.
    task automatic step(input bit ld, input bit md, input int din);
        @(negedge clk);
        load    = ld;
        mode    = md;
        datain  = 4'(din);
        dataout = 4'(ctr);
        ctr     = ref_next(ld, md, din, ctr);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst.trk.state", int'(st0), 0);
        check("rst.stp.state", int'(st1), 0);
        check("rst.trk.expected", int'(exp0), 0);
        check("rst.trk.err_pulse", int'(pl0), 0);
        check("rst.trk.err_count", int'(ec0), 0);
        check("rst.trk.match_count", int'(mc0), 0);
        check("rst.stp.err_count", int'(ec1), 0);
        check("rst.stp.match_count", int'(mc1), 0);
    endtask

    // Assert reset between edges, check it took effect without a clock,
    // release just after an edge so the first step lands on a clean cycle.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values();
        @(posedge clk);
        @(posedge clk);
        #1;
        load = 1'b0; mode = 1'b0; datain = '0; dataout = '0;
        ctr = 0;
        rst = 1'b1;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b1;

        // 1: correct up-count 0..11,0,1
        for (int k = 0; k < 14; k++) step(1'b0, 1'b1, 0);
        check("t1.match_count", int'(mc0), 13);
        check("t1.err_count", int'(ec0), 0);
        check("t1.expected", int'(exp0), 2);
        check("t1.state", int'(st0), 1);

        // 2: load 5, count down through the 0->11 wrap to 10
        step(1'b1, 1'b0, 5);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 0);
        check("t2.match_count", int'(mc0), 22);
        check("t2.stp.match_count", int'(mc1), 22);
        check("t2.err_count", int'(ec0), 0);
        check("t2.expected", int'(exp0), 9);

        // 3: show 7 where 3 is expected
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 0);
        check("t3.expected", int'(exp0), 3);
        ctr = 7;
        step(1'b0, 1'b0, 0);
        check("t3.err_pulse", int'(pl0), 1);
        check("t3.err_count", int'(ec0), 1);
        check("t3.stp.state", int'(st1), 2);
        check("t3.stp.err_count", int'(ec1), 1);
        step(1'b0, 1'b0, 0);
        check("t3.pulse_drop", int'(pl0), 0);
        check("t3.err_hold", int'(ec0), 1);
        check("t3.match_resume", int'(mc0), 29);

        // 4: sticky FAIL for 20 cycles with further corruption
        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 2) ctr = (ctr + 5) % 12;
            if (k == 10) step(1'b1, 1'b1, 8);
            else step(1'b0, 1'b0, 0);
        end
        check("t4.stp.state", int'(st1), 2);
        check("t4.stp.err_frozen", int'(ec1), 1);
        check("t4.stp.match_frozen", int'(mc1), 28);
        check("t4.trk.err_count", int'(ec0), 5);
        do_reset();

        // 5: saturation, out-of-range value, illegal load
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 0);
        check("t5.match_count", int'(mc0), 39);
        check("t5.stp.match_sat", int'(mc1), 31);
        ctr = 13;
        step(1'b0, 1'b1, 0);
        check("t5.oor.err_pulse", int'(pl0), 1);
        check("t5.oor.err_count", int'(ec0), 1);
        check("t5.oor.state", int'(st0), 0);
        check("t5.oor.stp.state", int'(st1), 2);
        step(1'b0, 1'b1, 0);
        check("t5.resync.state", int'(st0), 1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 0);
        step(1'b1, 1'b1, 14);
        check("t5.ill.state", int'(st0), 0);
        ctr = 6;
        step(1'b0, 1'b1, 0);
        check("t5.ill.no_err", int'(ec0), 1);
        check("t5.ill.state2", int'(st0), 1);
        step(1'b0, 1'b1, 0);
        check("t5.match_count2", int'(mc0), 44);

        // 6: wrap coverage, 25 up then 13 down from a fresh reset
        do_reset();
        for (int k = 0; k < 25; k++) step(1'b0, 1'b1, 0);
        for (int k = 0; k < 13; k++) step(1'b0, 1'b0, 0);
        check("t6.match_count", int'(mc0), 37);
        check("t6.err_count", int'(ec0), 0);
`ifdef MOD12_MON_WRAP_COV_EN
        check("t6.up_wrap", int'(uw0), 2);
        check("t6.down_wrap", int'(dw0), 1);
        check("t6.stp.up_wrap", int'(uw1), 2);
`endif

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

endmodule
